// File: rtl/uart_rx_loader.sv
// Purpose : pack bytes from a uart_rx handshake into little-endian words and write DEPTH words to a RAM port.
// Latency : rx_flush and wr_en are registered, one cycle after the byte event that causes them.
// Backpress: uart_rx holds rx_converted until flushed; every byte is flushed, so the source never stalls.
//
// Ports
//   clk, rst        system clock; synchronous active-high reset
//   start           arm a load (level-sampled in IDLE/DONE/ERROR, ignored in RECEIVE)
//   rx_data         byte from uart_rx
//   rx_converted    uart_rx byte ready, held until rx_flush
//   rx_data_valid   framing OK for the current byte
//   rx_flush        one-cycle pulse releasing the uart_rx byte
//   wr_en           one-cycle RAM write strobe
//   wr_addr         RAM word address (holds when wr_en=0)
//   wr_data         assembled word, lane 0 in bits [7:0] (holds when wr_en=0)
//   busy            high while receiving
//   done            high after the last word is written, until start or rst
//   timeout_err     high in ERROR; tied 0 unless the timeout feature is built
//
// Optional feature: define UART_RX_LOADER_TIMEOUT_EN to abort a stalled load
// after TIMEOUT_CYCLES idle cycles (ERROR state, timeout_err=1).

module uart_rx_loader #(
    parameter int ADDR_W         = 14,
    parameter int DEPTH          = 16384,
    parameter int WORD_BYTES     = 1,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [7:0]              rx_data,
    input  logic                    rx_converted,
    input  logic                    rx_data_valid,
    output logic                    rx_flush,
    output logic                    wr_en,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [8*WORD_BYTES-1:0] wr_data,
    output logic                    busy,
    output logic                    done,
    output logic                    timeout_err
);

    localparam int WORD_W = 8 * WORD_BYTES;
    localparam int LANE_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    // One extra bit so a full 2**ADDR_W load can still be counted to its end.
    localparam int CNT_W  = ADDR_W + 1;

    localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(DEPTH - 1);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(WORD_BYTES - 1);

    // Elaboration-time parameter sanity check.
    if (WORD_BYTES < 1 || WORD_BYTES > 4 || DEPTH < 1 ||
        DEPTH > (1 << ADDR_W) || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("uart_rx_loader: illegal parameter combination");
    end

`ifdef UART_RX_LOADER_TIMEOUT_EN
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECEIVE = 2'd1,
        ST_DONE    = 2'd2,
        ST_ERROR   = 2'd3
    } state_t;

    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic              started_q, started_d;
    logic              timeout_err_q, timeout_err_d;
`else
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECEIVE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;
`endif

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LANE_W-1:0]  lane_q, lane_d;
    logic [WORD_W-1:0]  asm_q, asm_d;
    logic               rx_flush_q, rx_flush_d;
    logic               wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [WORD_W-1:0]  wr_data_q, wr_data_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // A held rx_converted during our own flush cycle is the byte we just
    // released, not a new one.
    logic rx_event;
    logic accept;
    assign rx_event = rx_converted && !rx_flush_q;
    assign accept   = rx_event && rx_data_valid && (state_q == ST_RECEIVE);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lane_d     = lane_q;
        asm_d      = asm_q;
        rx_flush_d = rx_event;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        busy_d     = busy_q;
        done_d     = done_q;
`ifdef UART_RX_LOADER_TIMEOUT_EN
        idle_cnt_d    = idle_cnt_q;
        started_d     = started_q;
        timeout_err_d = timeout_err_q;
`endif

        case (state_q)
            ST_RECEIVE: begin
                if (accept) begin
                    for (int i = 0; i < WORD_BYTES; i++) begin
                        if (lane_q == LANE_W'(i)) begin
                            asm_d[8*i +: 8] = rx_data;
                        end
                    end
                    if (lane_q == LAST_LANE) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = cnt_q[ADDR_W-1:0];
                        wr_data_d = asm_d;
                        lane_d    = '0;
                        cnt_d     = cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_WORD) begin
                            state_d = ST_DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end else begin
                        lane_d = lane_q + LANE_W'(1);
                    end
`ifdef UART_RX_LOADER_TIMEOUT_EN
                    idle_cnt_d = '0;
                    started_d  = 1'b1;
                end else if (started_q) begin
                    // Count only once the load has begun; the host may take
                    // arbitrarily long to send the first byte.
                    if (idle_cnt_q == IDLE_LAST) begin
                        state_d       = ST_ERROR;
                        busy_d        = 1'b0;
                        timeout_err_d = 1'b1;
                        lane_d        = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                    end
`endif
                end
            end
            default: begin
                // IDLE, DONE and (optionally) ERROR: bytes are flushed and
                // dropped; start re-arms a fresh load.
                if (start) begin
                    state_d = ST_RECEIVE;
                    cnt_d   = '0;
                    lane_d  = '0;
                    asm_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
`ifdef UART_RX_LOADER_TIMEOUT_EN
                    idle_cnt_d    = '0;
                    started_d     = 1'b0;
                    timeout_err_d = 1'b0;
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            lane_q     <= '0;
            asm_q      <= '0;
            rx_flush_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef UART_RX_LOADER_TIMEOUT_EN
            idle_cnt_q    <= '0;
            started_q     <= 1'b0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lane_q     <= lane_d;
            asm_q      <= asm_d;
            rx_flush_q <= rx_flush_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef UART_RX_LOADER_TIMEOUT_EN
            idle_cnt_q    <= idle_cnt_d;
            started_q     <= started_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    assign rx_flush = rx_flush_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
`ifdef UART_RX_LOADER_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_loader.sv
// Directed bench: two loaders share one byte source.
//   dut_a: WORD_BYTES=2, DEPTH=4, TIMEOUT_CYCLES=100
//   dut_b: ADDR_W=2, WORD_BYTES=1, DEPTH=4 (full address space)

module tb_uart_rx_loader;

    logic        clk = 1'b0;
    logic        rst, start, rx_converted, rx_data_valid;
    logic [7:0]  rx_data;

    logic        a_flush, a_wr_en, a_busy, a_done, a_terr;
    logic [13:0] a_wr_addr;
    logic [15:0] a_wr_data;
    logic        b_flush, b_wr_en, b_busy, b_done, b_terr;
    logic [1:0]  b_wr_addr;
    logic [7:0]  b_wr_data;

    always #5 clk = ~clk;

    uart_rx_loader #(.ADDR_W(14), .DEPTH(4), .WORD_BYTES(2), .TIMEOUT_CYCLES(100)) dut_a (
        .clk(clk), .rst(rst), .start(start), .rx_data(rx_data),
        .rx_converted(rx_converted), .rx_data_valid(rx_data_valid),
        .rx_flush(a_flush), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .busy(a_busy), .done(a_done), .timeout_err(a_terr)
    );

    uart_rx_loader #(.ADDR_W(2), .DEPTH(4), .WORD_BYTES(1)) dut_b (
        .clk(clk), .rst(rst), .start(start), .rx_data(rx_data),
        .rx_converted(rx_converted), .rx_data_valid(rx_data_valid),
        .rx_flush(b_flush), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .busy(b_busy), .done(b_done), .timeout_err(b_terr)
    );

    int checks = 0;
    int fails  = 0;
    int flush_cnt = 0;

    logic [13:0] a_addr_q[$];
    logic [15:0] a_data_q[$];
    logic        a_done_q[$];
    logic [1:0]  b_addr_q[$];
    logic [7:0]  b_data_q[$];

    logic [15:0] exp_a [4] = '{16'h2211, 16'h4433, 16'h6655, 16'h8877};
    logic [7:0]  load_bytes [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

    // Write/flush monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (a_wr_en) begin
            a_addr_q.push_back(a_wr_addr);
            a_data_q.push_back(a_wr_data);
            a_done_q.push_back(a_done);
        end
        if (b_wr_en) begin
            b_addr_q.push_back(b_wr_addr);
            b_data_q.push_back(b_wr_data);
        end
        if (a_flush) flush_cnt++;
    end

    task automatic clear_logs();
        a_addr_q.delete(); a_data_q.delete(); a_done_q.delete();
        b_addr_q.delete(); b_data_q.delete();
        flush_cnt = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; rx_converted = 1'b0; rx_data_valid = 1'b0; rx_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        clear_logs();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Behaves like uart_rx: hold the byte until the loader flushes it.
    task automatic send_byte(input logic [7:0] d, input logic v);
        bit got = 0;
        rx_data = d; rx_data_valid = v; rx_converted = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (a_flush) begin got = 1; break; end
        end
        rx_converted = 1'b0; rx_data_valid = 1'b0;
        checks++;
        if (!got) begin
            $display("FAIL flush_wait: byte %h got no rx_flush within 20 cycles (required a pulse)", d);
            fails++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; rx_converted = 1'b0; rx_data_valid = 1'b0; rx_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({a_flush, a_wr_en, a_wr_addr, a_wr_data, a_busy, a_done, a_terr} !== '0) begin
            $display("FAIL reset_a: outputs %h, required 0",
                     {a_flush, a_wr_en, a_wr_addr, a_wr_data, a_busy, a_done, a_terr});
            fails++;
        end
        checks++;
        if ({b_flush, b_wr_en, b_wr_addr, b_wr_data, b_busy, b_done, b_terr} !== '0) begin
            $display("FAIL reset_b: outputs %h, required 0",
                     {b_flush, b_wr_en, b_wr_addr, b_wr_data, b_busy, b_done, b_terr});
            fails++;
        end
        rst = 1'b0;
        @(posedge clk); #1;
        clear_logs();
        send_byte(8'h5A, 1'b1);
        send_byte(8'hA5, 1'b1);
        checks++;
        if (flush_cnt !== 2) begin
            $display("FAIL reset_idle_flush: %0d flush pulses, required 2", flush_cnt);
            fails++;
        end
        checks++;
        if (a_data_q.size() + b_data_q.size() !== 0) begin
            $display("FAIL reset_idle_nowrite: %0d writes, required 0", a_data_q.size() + b_data_q.size());
            fails++;
        end
    endtask

    task automatic test_load();
        do_reset();
        pulse_start();
        checks++;
        if (a_busy !== 1'b1) begin
            $display("FAIL load_busy: busy=%b, required 1", a_busy);
            fails++;
        end
        for (int i = 0; i < 8; i++) send_byte(load_bytes[i], 1'b1);
        checks++;
        if (a_data_q.size() !== 4) begin
            $display("FAIL load_count: %0d writes, required 4", a_data_q.size());
            fails++;
        end
        for (int i = 0; i < 4; i++) begin
            logic [13:0] ga; logic [15:0] gd; logic gn;
            ga = (i < a_addr_q.size()) ? a_addr_q[i] : 'x;
            gd = (i < a_data_q.size()) ? a_data_q[i] : 'x;
            gn = (i < a_done_q.size()) ? a_done_q[i] : 'x;
            checks++;
            if (ga !== 14'(i) || gd !== exp_a[i] || gn !== (i == 3)) begin
                $display("FAIL load_word%0d: addr=%0d data=%h done=%b, required addr=%0d data=%h done=%b",
                         i, ga, gd, gn, i, exp_a[i], (i == 3));
                fails++;
            end
        end
        checks++;
        if (a_busy !== 1'b0 || a_done !== 1'b1) begin
            $display("FAIL load_end: busy=%b done=%b, required busy=0 done=1", a_busy, a_done);
            fails++;
        end
    endtask

    task automatic test_invalid_byte();
        do_reset();
        pulse_start();
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'hEE, 1'b0);
        for (int i = 2; i < 8; i++) send_byte(load_bytes[i], 1'b1);
        checks++;
        if (flush_cnt !== 9) begin
            $display("FAIL invalid_flush: %0d flush pulses, required 9", flush_cnt);
            fails++;
        end
        checks++;
        if (a_data_q.size() !== 4) begin
            $display("FAIL invalid_count: %0d writes, required 4", a_data_q.size());
            fails++;
        end
        for (int i = 0; i < 4; i++) begin
            logic [15:0] gd;
            gd = (i < a_data_q.size()) ? a_data_q[i] : 'x;
            checks++;
            if (gd !== exp_a[i]) begin
                $display("FAIL invalid_word%0d: data=%h, required %h", i, gd, exp_a[i]);
                fails++;
            end
        end
    endtask

    task automatic test_full_space();
        logic [7:0] exp_b [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        do_reset();
        pulse_start();
        for (int i = 0; i < 4; i++) send_byte(exp_b[i], 1'b1);
        checks++;
        if (b_data_q.size() !== 4 || b_done !== 1'b1 || b_busy !== 1'b0) begin
            $display("FAIL full_end: writes=%0d done=%b busy=%b, required 4/1/0",
                     b_data_q.size(), b_done, b_busy);
            fails++;
        end
        for (int i = 0; i < 4; i++) begin
            logic [1:0] ga; logic [7:0] gd;
            ga = (i < b_addr_q.size()) ? b_addr_q[i] : 'x;
            gd = (i < b_data_q.size()) ? b_data_q[i] : 'x;
            checks++;
            if (ga !== 2'(i) || gd !== exp_b[i]) begin
                $display("FAIL full_word%0d: addr=%0d data=%h, required addr=%0d data=%h",
                         i, ga, gd, i, exp_b[i]);
                fails++;
            end
        end
        send_byte(8'hB1, 1'b1);
        send_byte(8'hB2, 1'b1);
        checks++;
        if (b_data_q.size() !== 4 || flush_cnt !== 6) begin
            $display("FAIL full_after: writes=%0d flushes=%0d, required 4 and 6", b_data_q.size(), flush_cnt);
            fails++;
        end
        pulse_start();
        checks++;
        if (b_busy !== 1'b1 || b_done !== 1'b0) begin
            $display("FAIL full_rearm: busy=%b done=%b, required 1/0", b_busy, b_done);
            fails++;
        end
        send_byte(8'hC5, 1'b1);
        checks++;
        if (b_data_q.size() !== 5 || b_addr_q[$] !== 2'd0 || b_data_q[$] !== 8'hC5) begin
            $display("FAIL full_restart: writes=%0d last addr=%0d data=%h, required 5/0/c5",
                     b_data_q.size(), b_addr_q[$], b_data_q[$]);
            fails++;
        end
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        pulse_start();
        for (int i = 0; i < 3; i++) send_byte(load_bytes[i], 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (a_busy !== 1'b0 || a_wr_en !== 1'b0 || a_wr_data !== 16'h0) begin
            $display("FAIL midrst_state: busy=%b wr_en=%b wr_data=%h, required 0/0/0",
                     a_busy, a_wr_en, a_wr_data);
            fails++;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk); #1;
        checks++;
        if (a_data_q.size() !== 1) begin
            $display("FAIL midrst_partial: %0d writes, required 1 (partial word dropped)", a_data_q.size());
            fails++;
        end
        clear_logs();
        pulse_start();
        for (int i = 0; i < 8; i++) send_byte(load_bytes[i], 1'b1);
        checks++;
        if (a_data_q.size() !== 4 || a_done !== 1'b1) begin
            $display("FAIL midrst_reload: writes=%0d done=%b, required 4/1", a_data_q.size(), a_done);
            fails++;
        end
        for (int i = 0; i < 4; i++) begin
            logic [13:0] ga; logic [15:0] gd;
            ga = (i < a_addr_q.size()) ? a_addr_q[i] : 'x;
            gd = (i < a_data_q.size()) ? a_data_q[i] : 'x;
            checks++;
            if (ga !== 14'(i) || gd !== exp_a[i]) begin
                $display("FAIL midrst_word%0d: addr=%0d data=%h, required addr=%0d data=%h",
                         i, ga, gd, i, exp_a[i]);
                fails++;
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        pulse_start();
        for (int i = 0; i < 3; i++) send_byte(load_bytes[i], 1'b1);
        // One edge has passed since the last accept when send_byte returns.
`ifdef UART_RX_LOADER_TIMEOUT_EN
        repeat (98) @(posedge clk);
        #1;
        checks++;
        if (a_terr !== 1'b0 || a_busy !== 1'b1) begin
            $display("FAIL timeout_early: terr=%b busy=%b after 99 idle cycles, required 0/1", a_terr, a_busy);
            fails++;
        end
        @(posedge clk); #1;
        checks++;
        if (a_terr !== 1'b1 || a_busy !== 1'b0 || a_data_q.size() !== 1) begin
            $display("FAIL timeout_hit: terr=%b busy=%b writes=%0d after 100 idle cycles, required 1/0/1",
                     a_terr, a_busy, a_data_q.size());
            fails++;
        end
        pulse_start();
        checks++;
        if (a_terr !== 1'b0 || a_busy !== 1'b1) begin
            $display("FAIL timeout_rearm: terr=%b busy=%b, required 0/1", a_terr, a_busy);
            fails++;
        end
`else
        repeat (200) @(posedge clk);
        #1;
        checks++;
        if (a_terr !== 1'b0 || a_busy !== 1'b1) begin
            $display("FAIL notimeout_wait: terr=%b busy=%b, required 0/1", a_terr, a_busy);
            fails++;
        end
`endif
    endtask

    initial begin
        test_reset();
        test_load();
        test_invalid_byte();
        test_full_space();
        test_reset_mid_load();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
